// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction-fetch
// port (I) and a data port (D). A transaction runs IDLE -> BUSY (LATENCY
// cycles) -> RESP, so every access occupies the memory for LATENCY+2
// cycles. D normally wins a collision, but after two D grants made while a
// fetch was waiting, the fetch is granted so it cannot starve.
module mem_arbiter #(
    parameter int WORD_SIZE = 16,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic [WORD_SIZE-1:0] i_rdata,
    output logic                 i_ready,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_ready,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 i_or_d,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // BUSY lasts LATENCY cycles; the counter reaches zero in the last one.
    localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

    state_t               state_reg;
    logic [2:0]           cnt_reg;
    logic [1:0]           starve_reg;
    logic [WORD_SIZE-1:0] addr_reg;
    logic [WORD_SIZE-1:0] wdata_reg;
    logic [WORD_SIZE-1:0] i_rdata_reg;
    logic [WORD_SIZE-1:0] d_rdata_reg;
    logic                 we_reg;
    logic                 sel_d_reg;
    logic                 mem_read_reg;
    logic                 mem_write_reg;
    logic                 i_ready_reg;
    logic                 d_ready_reg;
    logic                 busy_reg;

    logic                 grant_d;
    logic                 grant_i;

    // Arbitration: D has priority unless the fetch port has been passed over twice.
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (d_req && (!i_req || starve_reg != 2'd2)) begin
            grant_d = 1'b1;
        end else if (i_req) begin
            grant_i = 1'b1;
        end
    end

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= 3'd0;
            starve_reg    <= 2'd0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            i_rdata_reg   <= '0;
            d_rdata_reg   <= '0;
            we_reg        <= 1'b0;
            sel_d_reg     <= 1'b0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            i_ready_reg   <= 1'b0;
            d_ready_reg   <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            // Ready outputs are single-cycle pulses.
            i_ready_reg <= 1'b0;
            d_ready_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_d) begin
                        state_reg     <= BUSY;
                        cnt_reg       <= CNT_INIT;
                        busy_reg      <= 1'b1;
                        addr_reg      <= d_addr;
                        wdata_reg     <= d_wdata;
                        we_reg        <= d_we;
                        sel_d_reg     <= 1'b1;
                        mem_read_reg  <= !d_we;
                        mem_write_reg <= d_we;
                        if (i_req && starve_reg != 2'd2) begin
                            starve_reg <= starve_reg + 2'd1;
                        end
                    end else if (grant_i) begin
                        // Fetches carry no store data, so mem_wdata keeps its last value.
                        state_reg     <= BUSY;
                        cnt_reg       <= CNT_INIT;
                        busy_reg      <= 1'b1;
                        addr_reg      <= i_addr;
                        we_reg        <= 1'b0;
                        sel_d_reg     <= 1'b0;
                        mem_read_reg  <= 1'b1;
                        mem_write_reg <= 1'b0;
                        starve_reg    <= 2'd0;
                    end
                end
                BUSY: begin
                    if (cnt_reg == 3'd0) begin
                        state_reg     <= RESP;
                        mem_read_reg  <= 1'b0;
                        mem_write_reg <= 1'b0;
                        if (!we_reg) begin
                            if (sel_d_reg) begin
                                d_rdata_reg <= mem_rdata;
                            end else begin
                                i_rdata_reg <= mem_rdata;
                            end
                        end
                        i_ready_reg <= !sel_d_reg;
                        d_ready_reg <= sel_d_reg;
                    end else begin
                        cnt_reg <= cnt_reg - 3'd1;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign i_rdata   = i_rdata_reg;
    assign i_ready   = i_ready_reg;
    assign d_rdata   = d_rdata_reg;
    assign d_ready   = d_ready_reg;
    assign mem_read  = mem_read_reg;
    assign mem_write = mem_write_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign i_or_d    = sel_d_reg;
    assign busy      = busy_reg;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default 16: width of addresses and data words.
REQ-002 Parameter LATENCY, default 2: memory access cycles per transaction, legal range 1..7.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 reset_n  in  1  synchronous reset; 1 = reset asserted, 0 = normal operation.
REQ-006 i_req  in  1  instruction-fetch read request; held high until i_ready.
REQ-007 i_addr  in  WORD_SIZE  fetch address.
REQ-008 i_rdata  out  WORD_SIZE  fetched instruction, registered.
REQ-009 i_ready  out  1  one-cycle pulse: i_rdata valid, fetch complete.
REQ-010 d_req  in  1  data-stage request; held high until d_ready.
REQ-011 d_we  in  1  1 = write, 0 = read.
REQ-012 d_addr  in  WORD_SIZE  data address.
REQ-013 d_wdata  in  WORD_SIZE  store data.
REQ-014 d_rdata  out  WORD_SIZE  load data, registered.
REQ-015 d_ready  out  1  one-cycle pulse: data access complete.
REQ-016 mem_read  out  1  memory read strobe.
REQ-017 mem_write  out  1  memory write strobe.
REQ-018 mem_addr  out  WORD_SIZE  memory address.
REQ-019 mem_wdata  out  WORD_SIZE  memory write data.
REQ-020 mem_rdata  in  WORD_SIZE  memory read data, valid in last BUSY cycle.
REQ-021 i_or_d  out  1  0 = current/last grant is fetch, 1 = data.
REQ-022 busy  out  1  high in BUSY and RESP states.

Function
REQ-023 FSM states IDLE, BUSY, RESP; grants are made only in IDLE.
REQ-024 IDLE: d_req=1 and i_req=0 -> grant D; i_req=1 and d_req=0 -> grant I; neither -> stay IDLE.
REQ-025 Both requests in IDLE: grant D, unless starve_cnt=2, then grant I.
REQ-026 starve_cnt (2 bits): +1 on each D grant while i_req=1; cleared on every I grant; saturates at 2.
REQ-027 Grant cycle T: latch address, write data, d_we (forced 0 for I), i_or_d; next state BUSY.
REQ-028 BUSY lasts exactly LATENCY cycles (T+1..T+LATENCY); down-counter loaded with LATENCY-1 at grant, decrements each BUSY cycle.
REQ-029 In BUSY: mem_addr/mem_wdata/i_or_d drive latched values; mem_read = !we_latched, mem_write = we_latched.
REQ-030 Last BUSY cycle (counter=0): read transaction captures mem_rdata into i_rdata or d_rdata per granted port; next state RESP.
REQ-031 RESP (cycle T+LATENCY+1): pulse i_ready or d_ready for the granted port only, one cycle; next state IDLE.
REQ-032 Total occupancy per transaction LATENCY+2 cycles; no back-to-back grant without an intervening IDLE cycle.
REQ-033 Write transaction leaves d_rdata unchanged; i_rdata/d_rdata hold their value until next capture for that port.
REQ-034 In IDLE and RESP: mem_read=0, mem_write=0; mem_addr, mem_wdata, i_or_d hold last latched values.
REQ-035 Request deassertion or input change during BUSY/RESP is ignored; the transaction completes on latched values.
REQ-036 A request still high in the IDLE cycle after its ready pulse is treated as a new request.
REQ-037 i_ready and d_ready are never high in the same cycle.

Reset
REQ-038 reset_n=1 at a rising edge: state IDLE, counter 0, starve_cnt 0, all outputs and latched registers 0.
REQ-039 Reset mid-BUSY or in RESP aborts the transaction: no ready pulse, no rdata capture, strobes low next cycle.
REQ-040 Reset overrides simultaneous requests; first grant is possible in the first cycle with reset_n=0.

Verification (LATENCY=2)
REQ-041 i_req=1, i_addr=0x0010, mem_rdata=0xA5A5 -> mem_read high 2 cycles with mem_addr=0x0010, i_or_d=0, i_ready pulse at T+3, i_rdata=0xA5A5.
REQ-042 d_req=1, d_we=1, d_addr=0x0100, d_wdata=0x1234 -> mem_write high 2 cycles, mem_wdata=0x1234, i_or_d=1, d_ready at T+3, d_rdata unchanged.
REQ-043 i_req and d_req both high continuously -> grant order D, D, I, D, D, I; ready pulses every 4 cycles.
REQ-044 Reset asserted at T+1 of a read -> no i_ready, mem_read 0, all outputs 0, next request served normally.
REQ-045 d_addr changed 0x0100 -> 0x0200 during BUSY -> mem_addr stays 0x0100 through transaction.
REQ-046 LATENCY=1 and LATENCY=7 builds: ready pulse at T+2 and T+8 respectively.
